// File: rtl/phase_timer.sv
// Phase-duration timer: divides clk to a tick and counts a loaded phase length down to 1.
// Load beats hold, hold beats tick; the count saturates at 1 so a phase can be extended.
module phase_timer #(
  parameter int CNT_W       = 5,
  parameter int TICK_DIV    = 50_000_000,
  parameter int RESET_VALUE = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_counter,
  input  logic [CNT_W-1:0] load_value,
  input  logic             hold,
  output logic [CNT_W-1:0] counter_value,
  output logic             tick,
  output logic             expired
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RESET_VALUE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A zero phase length is meaningless to the controller; treat it as one tick.
  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v > CNT_ONE) ? (v - CNT_ONE) : CNT_ONE;
  endfunction

  logic [PS_W-1:0]  prescaler;
  logic [PS_W-1:0]  prescaler_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tick_nxt;

  always_comb begin
    prescaler_nxt = prescaler;
    cnt_nxt       = counter_value;
    tick_nxt      = 1'b0;
    if (load_counter) begin
      cnt_nxt       = clamp_load(load_value);
      prescaler_nxt = '0;
    end else if (hold) begin
      prescaler_nxt = prescaler;
    end else if (prescaler == PS_LAST) begin
      prescaler_nxt = '0;
      cnt_nxt       = sat_dec(counter_value);
      tick_nxt      = 1'b1;
    end else begin
      prescaler_nxt = prescaler + 1'b1;
    end
  end

  // Output register stage: expired derives from cnt_nxt so it tracks counter_value exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler     <= '0;
      counter_value <= CNT_RST;
      tick          <= 1'b0;
      expired       <= (RESET_VALUE == 1);
    end else begin
      prescaler     <= prescaler_nxt;
      counter_value <= cnt_nxt;
      tick          <= tick_nxt;
      expired       <= (cnt_nxt == CNT_ONE);
    end
  end

endmodule
